fifo_pack_param: RTL and testbench

// Parametrised multi-lane in-order packing FIFO; successor of the fixed 9-push/6-pop 80-bit packer.

---
 rtl/fifo_pack_param.sv | 83 ++++++++
 tb/tb_fifo_pack_param.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fifo_pack_param.sv
// fifo_pack_param: parametrised multi-lane in-order packing FIFO with flush, count and almost_full
module fifo_pack_param #(
  parameter int NUM_PUSH  = 9,
  parameter int NUM_POP   = 6,
  parameter int DATA_W    = 80,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         test_en,
  input  logic                         flush,
  input  logic [NUM_PUSH-1:0]          push_valid,
  output logic [NUM_PUSH-1:0]          push_ready,
  input  logic [NUM_PUSH*DATA_W-1:0]   push_data,
  output logic [NUM_POP-1:0]           pop_valid,
  input  logic [NUM_POP-1:0]           pop_ready,
  output logic [NUM_POP*DATA_W-1:0]    pop_data,
  output logic [CW-1:0]                count,
  output logic                         almost_full
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, free, vcnt, pushed, popped;
  logic almost_full_q, almost_full_d, run;
  logic unused_test_en;
  assign unused_test_en = test_en;
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    return PW'(s >= DEPTH ? s - DEPTH : s);
  endfunction
  always_comb begin
    free = CW'(DEPTH) - count_q;
    vcnt = '0;
    pushed = '0;
    popped = '0;
    run = 1'b1;
    push_ready = '0;
    pop_valid = '0;
    pop_data = '0;
    mem_d = mem_q;
    for (int i = 0; i < NUM_PUSH; i++) begin
      push_ready[i] = !flush && (vcnt < free);
      if (push_valid[i] && push_ready[i]) begin
        mem_d[wrap(wr_ptr_q, int'(pushed))] = push_data[i*DATA_W +: DATA_W];
        pushed = pushed + CW'(1);
      end
      vcnt = vcnt + CW'(push_valid[i]);
    end
    for (int j = 0; j < NUM_POP; j++) begin
      pop_valid[j] = !flush && (CW'(j) < count_q);
      pop_data[j*DATA_W +: DATA_W] = mem_q[wrap(rd_ptr_q, j)];
      run = run && pop_valid[j] && pop_ready[j];
      popped = popped + CW'(run);
    end
    count_d = flush ? '0 : count_q + pushed - popped;
    wr_ptr_d = flush ? '0 : wrap(wr_ptr_q, int'(pushed));
    rd_ptr_d = flush ? '0 : wrap(rd_ptr_q, int'(popped));
    almost_full_d = !flush && (int'(count_d) >= AF_THRESH);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      almost_full_q <= 1'b0;
    end else begin
      count_q <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      almost_full_q <= almost_full_d;
    end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign count = count_q;
  assign almost_full = almost_full_q;
`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!reset_n) (pop_ready & (pop_ready + NUM_POP'(1))) == '0);
`endif
endmodule

// File: tb/tb_fifo_pack_param.sv
// tb_fifo_pack_param: scoreboard bench for fifo_pack_param
module tb_fifo_pack_param;
  localparam int NP = 9, NQ = 6, DW = 80, DEPTH = 16, AF = 12;
  localparam int CW = $clog2(DEPTH + 1);
  logic clk = 0, reset_n = 0, test_en = 0, flush = 0;
  logic [NP-1:0] push_valid = '0, push_ready;
  logic [NP*DW-1:0] push_data = '0;
  logic [NQ-1:0] pop_valid, pop_ready = '0;
  logic [NQ*DW-1:0] pop_data;
  logic [CW-1:0] count;
  logic almost_full;
  int vectors = 0, miscompares = 0, mcount = 0, total_acc = 0;
  logic [DW-1:0] q[$];
  always #5 clk = ~clk;
  fifo_pack_param #(.NUM_PUSH(NP), .NUM_POP(NQ), .DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .reset_n(reset_n), .test_en(test_en), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count), .almost_full(almost_full)
  );
  function automatic logic [NP*DW-1:0] seq_data(input int base);
    logic [NP*DW-1:0] d;
    for (int i = 0; i < NP; i++) d[i*DW +: DW] = DW'(base + i);
    return d;
  endfunction
  task automatic step(input logic [NP-1:0] pv, input logic [NP*DW-1:0] pd, input logic [NQ-1:0] pr, input logic fl);
    logic [NP-1:0] er;
    logic [NQ-1:0] ev;
    int vc, n;
    bit run;
    logic [DW-1:0] newq[$];
    vc = 0; n = 0; run = 1;
    push_valid = pv; push_data = pd; pop_ready = pr; flush = fl;
    @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      er[i] = !fl && (vc < DEPTH - mcount);
      if (pv[i]) begin
        if (er[i]) newq.push_back(pd[i*DW +: DW]);
        vc++;
      end
    end
    for (int j = 0; j < NQ; j++) begin
      ev[j] = !fl && (j < mcount);
      run = run && ev[j] && pr[j];
      if (run) n++;
    end
    vectors++;
    if (push_ready !== er) begin miscompares++; $display("FAIL push_ready: got %h exp %h", push_ready, er); end
    vectors++;
    if (pop_valid !== ev) begin miscompares++; $display("FAIL pop_valid: got %b exp %b", pop_valid, ev); end
    for (int j = 0; j < NQ; j++)
      if (ev[j]) begin
        vectors++;
        if (pop_data[j*DW +: DW] !== q[j]) begin
          miscompares++;
          $display("FAIL pop_data[%0d]: got %h exp %h", j, pop_data[j*DW +: DW], q[j]);
        end
      end
    if (fl) begin
      q.delete();
      mcount = 0;
    end else begin
      repeat (n) void'(q.pop_front());
      foreach (newq[k]) q.push_back(newq[k]);
      mcount = mcount + newq.size() - n;
      total_acc += newq.size();
    end
    @(posedge clk); #1;
    vectors++;
    if (count !== CW'(mcount)) begin miscompares++; $display("FAIL count: got %0d exp %0d", count, mcount); end
    vectors++;
    if (almost_full !== (mcount >= AF)) begin miscompares++; $display("FAIL almost_full: got %b exp %b", almost_full, mcount >= AF); end
  endtask
  task automatic test_reset();
    #12;
    vectors++;
    if (count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d exp 0", count); end
    vectors++;
    if (pop_valid !== '0) begin miscompares++; $display("FAIL reset_pop_valid: got %b exp 0", pop_valid); end
    vectors++;
    if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_almost_full: got %b exp 0", almost_full); end
    @(posedge clk); #1;
    reset_n = 1;
    #1;
    vectors++;
    if (push_ready !== '1) begin miscompares++; $display("FAIL reset_push_ready: got %h exp 1ff", push_ready); end
  endtask
  task automatic test_fill();
    step('1, seq_data(0), '0, 0);
    vectors++;
    if (count !== CW'(9)) begin miscompares++; $display("FAIL fill_count1: got %0d exp 9", count); end
    step('1, seq_data(9), '0, 0);
    vectors++;
    if (count !== CW'(16) || almost_full !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_full: got count %0d af %b exp 16 1", count, almost_full);
    end
  endtask
  task automatic test_full_pop();
    step('1, seq_data(100), '1, 0);
    vectors++;
    if (count !== CW'(10)) begin miscompares++; $display("FAIL full_pop_count: got %0d exp 10", count); end
  endtask
  task automatic test_flush();
    step('1, seq_data(200), '1, 1);
    vectors++;
    if (count !== '0 || almost_full !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_state: got count %0d af %b exp 0 0", count, almost_full);
    end
    step('0, '0, '1, 0);
  endtask
  task automatic test_sparse();
    logic [NP*DW-1:0] d;
    d = '0;
    d[1*DW +: DW] = DW'(80'hA);
    d[4*DW +: DW] = DW'(80'hB);
    d[7*DW +: DW] = DW'(80'hC);
    step(9'b010010010, d, '0, 0);
    step('0, '0, '0, 0);
    vectors++;
    if (pop_valid !== 6'b000111) begin miscompares++; $display("FAIL sparse_pop_valid: got %b exp 000111", pop_valid); end
    step('0, '0, '1, 0);
  endtask
  task automatic test_random();
    logic [NP-1:0] pv;
    logic [NP*DW-1:0] pd;
    logic [NQ-1:0] pr;
    int k, start, cyc;
    start = total_acc;
    cyc = 0;
    while (total_acc - start < 100 && cyc < 3000) begin
      for (int i = 0; i < NP; i++) begin
        pv[i] = $urandom_range(99) < 40;
        pd[i*DW +: DW] = DW'({$urandom, $urandom, $urandom});
      end
      k = ($urandom_range(25) < 20) ? $urandom_range(NQ, 1) : 0;
      pr = NQ'((1 << k) - 1);
      step(pv, pd, pr, 0);
      cyc++;
    end
    vectors++;
    if (total_acc - start < 100) begin miscompares++; $display("FAIL random_budget: got %0d exp 100", total_acc - start); end
    for (int c = 0; c < 20 && mcount > 0; c++) step('0, '0, '1, 0);
  endtask
  task automatic test_async_reset();
    step(9'h07F, seq_data(300), '0, 0);
    push_valid = '1; push_data = seq_data(400);
    #2 reset_n = 0;
    #1;
    vectors++;
    if (count !== '0 || pop_valid !== '0 || almost_full !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got count %0d pv %b af %b exp 0 0 0", count, pop_valid, almost_full);
    end
    q.delete();
    mcount = 0;
    push_valid = '0;
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
    step(9'h155, seq_data(500), '0, 0);
    step('1, seq_data(600), 6'b000111, 0);
    step('0, '0, '1, 0);
    step('0, '0, '1, 0);
    step('0, '0, '1, 0);
  endtask
  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_flush();
    test_sparse();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
